// File: rtl/stopwatch_disp_core_if.sv
// Stopwatch core bus: control strobes in, display/count state out.
//   master : strobe driver (divider / control logic / bench)
//   slave  : stopwatch_disp_core
//   cnt_tick, scan_tick, start_stop, clear : single-cycle strobes
//   an[3:0], seg[6:0], dp                  : active-low display lines
//   bcd[15:0], running, ovf                : count state
interface stopwatch_disp_core_if;
   logic        cnt_tick;
   logic        scan_tick;
   logic        start_stop;
   logic        clear;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [15:0] bcd;
   logic        running;
   logic        ovf;

   modport master (
      output cnt_tick, scan_tick, start_stop, clear,
      input  an, seg, dp, bcd, running, ovf
   );

   modport slave (
      input  cnt_tick, scan_tick, start_stop, clear,
      output an, seg, dp, bcd, running, ovf
   );
endinterface

// File: rtl/stopwatch_disp_core.sv
// Four-digit BCD stopwatch with start/stop/clear control and a registered
// four-digit seven-segment scanner. Strobes are clock enables on clk.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : slave side of stopwatch_disp_core_if (strobes in, display out)
// Parameters:
//   WRAP   : 1 = 9999 wraps to 0000, 0 = count holds at 9999
//   DP_POS : digit index (0 = rightmost) with the decimal point lit
module stopwatch_disp_core #(
   parameter int unsigned WRAP   = 1,
   parameter int unsigned DP_POS = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   stopwatch_disp_core_if.slave   bus
);

   localparam int unsigned NDIG  = 4;
   localparam int unsigned DIG_W = 4;
   localparam int unsigned CNT_W = NDIG * DIG_W;
   localparam int unsigned PTR_W = 2;
   localparam int unsigned SEG_W = 7;

   localparam logic [CNT_W-1:0] CNT_MAX = 16'h9999;
   localparam logic [SEG_W-1:0] SEG_ZERO = 7'b1000000;
   localparam logic             DP_RST   = (DP_POS == 0) ? 1'b0 : 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic               running_q, running_d;
   logic [CNT_W-1:0]   bcd_q, bcd_d;
   logic               ovf_q, ovf_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [3:0]         an_q, an_d;
   logic [SEG_W-1:0]   seg_q, seg_d;
   logic               dp_q, dp_d;

   logic               inc;
   logic [DIG_W-1:0]   cur_digit;

   // Add one to a four-digit BCD value, carry rippling d0 -> d3.
   function automatic logic [CNT_W-1:0] bcd_plus1(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      logic             c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < int'(NDIG); i++) begin
         if (c) begin
            if (v[i*DIG_W +: DIG_W] == 4'd9) begin
               r[i*DIG_W +: DIG_W] = 4'd0;
            end else begin
               r[i*DIG_W +: DIG_W] = v[i*DIG_W +: DIG_W] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit.
   function automatic logic [SEG_W-1:0] seg_decode(input logic [DIG_W-1:0] d);
      logic [SEG_W-1:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; clear overrides start_stop.
   always_comb begin
      state_d = state_q;
      if (bus.clear) begin
         state_d = ST_IDLE;
      end else if (bus.start_stop) begin
         case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_PAUSE;
            ST_PAUSE: state_d = ST_RUN;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // FSM output: running tracks the state being entered.
   always_comb begin
      running_d = 1'b0;
      if (state_d == ST_RUN) begin
         running_d = 1'b1;
      end
   end

   // Count and scan next-state. The increment keys off the registered state,
   // so a tick coincident with start_stop counts when leaving RUN only.
   always_comb begin
      inc       = (state_q == ST_RUN) && bus.cnt_tick && !bus.clear;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      if (bus.clear) begin
         bcd_d = '0;
         ovf_d = 1'b0;
      end else if (inc) begin
         if (bcd_q == CNT_MAX) begin
            ovf_d = 1'b1;
            bcd_d = (WRAP != 0) ? '0 : CNT_MAX;
         end else begin
            bcd_d = bcd_plus1(bcd_q);
         end
      end

      // Display fields use the advanced pointer and the pre-increment count.
      ptr_d     = ptr_q + PTR_W'(bus.scan_tick);
      cur_digit = bcd_q[ptr_d*DIG_W +: DIG_W];
      an_d      = ~(4'b0001 << ptr_d);
      seg_d     = seg_decode(cur_digit);
      dp_d      = (ptr_d == PTR_W'(DP_POS)) ? 1'b0 : 1'b1;
   end

   // Datapath and display registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         running_q <= 1'b0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         ptr_q     <= '0;
         an_q      <= 4'b1110;
         seg_q     <= SEG_ZERO;
         dp_q      <= DP_RST;
      end else begin
         running_q <= running_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
         ptr_q     <= ptr_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
      end
   end

   assign bus.an      = an_q;
   assign bus.seg     = seg_q;
   assign bus.dp      = dp_q;
   assign bus.bcd     = bcd_q;
   assign bus.running = running_q;
   assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_stopwatch_disp_core.sv
// Directed bench for stopwatch_disp_core: one WRAP=1 and one WRAP=0 instance
// driven with identical strobes, checked against hand-computed values.
module tb_stopwatch_disp_core;

   logic clk;
   logic reset;
   logic cnt_tick, scan_tick, start_stop, clear;

   int total;
   int bad;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S9 = 7'b0010000;

   stopwatch_disp_core_if bw ();
   stopwatch_disp_core_if bh ();

   assign bw.cnt_tick   = cnt_tick;
   assign bw.scan_tick  = scan_tick;
   assign bw.start_stop = start_stop;
   assign bw.clear      = clear;
   assign bh.cnt_tick   = cnt_tick;
   assign bh.scan_tick  = scan_tick;
   assign bh.start_stop = start_stop;
   assign bh.clear      = clear;

   stopwatch_disp_core #(.WRAP(1), .DP_POS(2)) dut_wrap (
      .clk   (clk),
      .reset (reset),
      .bus   (bw.slave)
   );

   stopwatch_disp_core #(.WRAP(0), .DP_POS(2)) dut_hold (
      .clk   (clk),
      .reset (reset),
      .bus   (bh.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 ns after it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      cnt_tick = 1'b1;
      repeat (n) cyc();
      cnt_tick = 1'b0;
   endtask

   task automatic scan_once();
      scan_tick = 1'b1;
      cyc();
      scan_tick = 1'b0;
   endtask

   task automatic toggle_run();
      start_stop = 1'b1;
      cyc();
      start_stop = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      cnt_tick = 1'b0; scan_tick = 1'b0; start_stop = 1'b0; clear = 1'b0;

      // Reset values
      #12;
      chk("rst_an",   32'(bw.an), 32'h0000000e);
      chk("rst_seg",  32'(bw.seg), 32'(S0));
      chk("rst_dp",   32'(bw.dp), 32'd1);
      chk("rst_bcd",  32'(bw.bcd), 32'h0);
      chk("rst_run",  32'(bw.running), 32'd0);
      chk("rst_ovf",  32'(bw.ovf), 32'd0);
      #1 reset = 1'b1;

      // Scan walk
      cyc();
      chk("idle_an", 32'(bw.an), 32'h0000000e);
      scan_once();
      chk("scan1_an", 32'(bw.an), 32'h0000000d);
      chk("scan1_dp", 32'(bw.dp), 32'd1);
      scan_once();
      chk("scan2_an", 32'(bw.an), 32'h0000000b);
      chk("scan2_dp", 32'(bw.dp), 32'd0);
      chk("scan2_seg", 32'(bw.seg), 32'(S0));
      scan_once();
      chk("scan3_an", 32'(bw.an), 32'h00000007);
      chk("scan3_dp", 32'(bw.dp), 32'd1);
      scan_once();
      chk("scan4_an", 32'(bw.an), 32'h0000000e);

      // Start and count 12; entering tick not counted
      toggle_run();
      chk("start_run", 32'(bw.running), 32'd1);
      chk("start_bcd", 32'(bw.bcd), 32'h0);
      ticks(12);
      chk("cnt12_bcd", 32'(bw.bcd), 32'h0012);
      chk("cnt12_run", 32'(bw.running), 32'd1);
      scan_once();
      chk("ptr1_an",  32'(bw.an), 32'h0000000d);
      chk("ptr1_seg", 32'(bw.seg), 32'(S1));

      // Ripple carry and tick coincident with pause
      ticks(987);
      chk("cnt999_bcd", 32'(bw.bcd), 32'h0999);
      ticks(1);
      chk("carry_bcd", 32'(bw.bcd), 32'h1000);
      cnt_tick = 1'b1; start_stop = 1'b1;
      cyc();
      cnt_tick = 1'b0; start_stop = 1'b0;
      chk("pause_bcd", 32'(bw.bcd), 32'h1001);
      chk("pause_run", 32'(bw.running), 32'd0);
      ticks(3);
      chk("paused_bcd", 32'(bw.bcd), 32'h1001);

      // Resume and reach 9999
      toggle_run();
      chk("resume_run", 32'(bw.running), 32'd1);
      ticks(8998);
      chk("max_bcd_w", 32'(bw.bcd), 32'h9999);
      chk("max_bcd_h", 32'(bh.bcd), 32'h9999);
      chk("max_ovf_w", 32'(bw.ovf), 32'd0);
      ticks(1);
      chk("wrap_bcd", 32'(bw.bcd), 32'h0000);
      chk("wrap_ovf", 32'(bw.ovf), 32'd1);
      chk("wrap_run", 32'(bw.running), 32'd1);
      chk("hold_bcd", 32'(bh.bcd), 32'h9999);
      chk("hold_ovf", 32'(bh.ovf), 32'd1);
      chk("hold_run", 32'(bh.running), 32'd1);
      chk("hold_seg", 32'(bh.seg), 32'(S9));
      ticks(1);
      chk("wrap2_bcd", 32'(bw.bcd), 32'h0001);
      chk("wrap2_ovf", 32'(bw.ovf), 32'd1);
      chk("hold2_bcd", 32'(bh.bcd), 32'h9999);

      // Clear wins over tick and start_stop
      clear = 1'b1; cnt_tick = 1'b1; start_stop = 1'b1;
      cyc();
      clear = 1'b0; cnt_tick = 1'b0; start_stop = 1'b0;
      chk("clr_bcd", 32'(bw.bcd), 32'h0);
      chk("clr_run", 32'(bw.running), 32'd0);
      chk("clr_ovf", 32'(bw.ovf), 32'd0);
      chk("clr_ovf_h", 32'(bh.ovf), 32'd0);
      ticks(2);
      chk("idle_bcd", 32'(bw.bcd), 32'h0);

      // Async reset mid-count at ptr=2
      toggle_run();
      ticks(457);
      chk("c457_bcd", 32'(bw.bcd), 32'h0457);
      scan_once();
      chk("ptr2_an",  32'(bw.an), 32'h0000000b);
      chk("ptr2_seg", 32'(bw.seg), 32'(S4));
      chk("ptr2_dp",  32'(bw.dp), 32'd0);
      #2 reset = 1'b0;
      #1;
      chk("arst_bcd", 32'(bw.bcd), 32'h0);
      chk("arst_an",  32'(bw.an), 32'h0000000e);
      chk("arst_seg", 32'(bw.seg), 32'(S0));
      chk("arst_dp",  32'(bw.dp), 32'd1);
      chk("arst_run", 32'(bw.running), 32'd0);
      #2 reset = 1'b1;
      toggle_run();
      ticks(1);
      chk("post_bcd", 32'(bw.bcd), 32'h0001);
      chk("post_run", 32'(bw.running), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
